// File: rtl/dds_word_sequencer_if.sv
// Word/handshake bundle between the sequencer and the DDS SPI word writer.
// Signals: dds_control (word), dds_control_update (load strobe), spi_ready (writer idle).
interface dds_word_sequencer_if;
    logic [15:0] dds_control;
    logic        dds_control_update;
    logic        spi_ready;

    modport master (
        output dds_control,
        output dds_control_update,
        input  spi_ready
    );

    modport slave (
        input  dds_control,
        input  dds_control_update,
        output spi_ready
    );
endinterface

// File: rtl/dds_word_sequencer.sv
// Plays a host-programmed table of 16-bit words into the DDS SPI writer,
// pacing on spi_ready with a programmable inter-word gap; single-shot or looped.
// Ports: clk, rstn (sync, active low); tbl_wr_en/addr/data (table write);
//   start, abort, loop_en, seq_len, gap_cycles (control, latched on start);
//   dds (writer bundle, master); busy, done, word_idx, skip_count (status).
// Option: define DDS_SEQ_DEDUP_EN to skip table words equal to the last issued word.
module dds_word_sequencer #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int GAP_W       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tbl_wr_en,
    input  logic [AW-1:0]       tbl_wr_addr,
    input  logic [15:0]         tbl_wr_data,
    input  logic                start,
    input  logic                abort,
    input  logic                loop_en,
    input  logic [AW:0]         seq_len,
    input  logic [GAP_W-1:0]    gap_cycles,
    dds_word_sequencer_if.master dds,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       word_idx,
    output logic [7:0]          skip_count
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [15:0]      tbl [DEPTH];
    logic [AW-1:0]    idx, idx_nxt;
    logic [AW:0]      len, len_nxt;
    logic [GAP_W-1:0] gap, gap_nxt;
    logic [GAP_W-1:0] gcnt, gcnt_nxt;
    logic             lp, lp_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic [15:0]      ctl, ctl_nxt;
    logic             upd, upd_nxt;
    logic             busy_nxt, done_nxt;
    logic [AW-1:0]    word_idx_nxt;
    logic [7:0]       skip_nxt, skip_inc;
    logic [15:0]      cur;
    logic             last, dup;

    // Table has no reset; host contents survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // Entry is read live at issue time so late host writes still land.
    assign cur      = tbl[idx];
    assign last     = ({1'b0, idx} == len - 1'b1);
    assign skip_inc = (skip_count == 8'hFF) ? skip_count : skip_count + 8'd1;

`ifdef DDS_SEQ_DEDUP_EN
    // ctl holds the last issued word (0 out of reset).
    assign dup = (cur == ctl);
`else
    assign dup = 1'b0;
`endif

    assign dds.dds_control        = ctl;
    assign dds.dds_control_update = upd;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            idx        <= '0;
            len        <= '0;
            gap        <= '0;
            gcnt       <= '0;
            lp         <= 1'b0;
            tcnt       <= '0;
            ctl        <= '0;
            upd        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_idx   <= '0;
            skip_count <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            len        <= len_nxt;
            gap        <= gap_nxt;
            gcnt       <= gcnt_nxt;
            lp         <= lp_nxt;
            tcnt       <= tcnt_nxt;
            ctl        <= ctl_nxt;
            upd        <= upd_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            word_idx   <= word_idx_nxt;
            skip_count <= skip_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        len_nxt      = len;
        gap_nxt      = gap;
        gcnt_nxt     = gcnt;
        lp_nxt       = lp;
        tcnt_nxt     = tcnt;
        ctl_nxt      = ctl;
        upd_nxt      = 1'b0;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        word_idx_nxt = word_idx;
        skip_nxt     = skip_count;

        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (seq_len == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            len_nxt   = seq_len;
                            gap_nxt   = gap_cycles;
                            lp_nxt    = loop_en;
                            idx_nxt   = '0;
                            busy_nxt  = 1'b1;
                            state_nxt = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (dup) begin
                        skip_nxt     = skip_inc;
                        word_idx_nxt = idx;
                        gcnt_nxt     = '0;
                        state_nxt    = S_GAP;
                    end else if (dds.spi_ready) begin
                        ctl_nxt      = cur;
                        upd_nxt      = 1'b1;
                        word_idx_nxt = idx;
                        tcnt_nxt     = '0;
                        state_nxt    = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // Writer drops a repeated word silently, so a missing
                    // spi_ready fall is counted as a skipped word.
                    if (!dds.spi_ready) begin
                        state_nxt = S_WAIT_DONE;
                    end else if (tcnt + 1'b1 == TW'(ACK_TIMEOUT)) begin
                        skip_nxt  = skip_inc;
                        gcnt_nxt  = '0;
                        state_nxt = S_GAP;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (dds.spi_ready) begin
                        gcnt_nxt  = '0;
                        state_nxt = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gcnt != gap) begin
                        gcnt_nxt = gcnt + 1'b1;
                    end else if (!last) begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (lp) begin
                        idx_nxt   = '0;
                        state_nxt = S_ISSUE;
                    end else begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = S_FINISH;
                    end
                end
                S_FINISH: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dds_word_sequencer.md
Name: dds_word_sequencer

Overview:
Scheduler that drives the DDS SPI word writer through a programmed list of 16-bit control words, e.g. DDS init followed by a frequency/phase step list.
- Holds a small word table written by the host register block.
- On start, issues each word on dds_control/dds_control_update, paces on the writer's spi_ready, then waits a programmable gap before the next word.
- Supports single-shot and looped playback plus abort.
- Sits between the host register file and the DDS SPI writer; it is the writer's only source of words.

Parameters:
DEPTH, 16, number of table entries (power of two)
AW, 4, table address width, log2(DEPTH)
GAP_W, 16, width of inter-word gap counter
ACK_TIMEOUT, 8, cycles to wait for spi_ready to fall after an update before treating the word as suppressed (must be >= 4)

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous active-low
tbl_wr_en  input  1  table write strobe
tbl_wr_addr  input  AW  table write address
tbl_wr_data  input  16  table write data
start  input  1  single-cycle start pulse
abort  input  1  single-cycle abort pulse
loop_en  input  1  replay table from index 0 after last word
seq_len  input  AW+1  number of words to play, 0..DEPTH
gap_cycles  input  GAP_W  idle cycles between end of one word and issue of next
spi_ready  input  1  writer idle (high) / shifting (low)
dds_control  output  16  word to writer
dds_control_update  output  1  one-cycle load strobe to writer
busy  output  1  sequence in progress
done  output  1  one-cycle pulse at normal completion
word_idx  output  AW  index of most recently issued word
skip_count  output  8  saturating count of words the writer did not send

Behaviour:
- Reset, clocked when rstn low: all outputs 0, FSM to IDLE. Table contents are not reset.
- Table write: accepted every cycle in any state. ISSUE reads the entry live, so a write takes effect if it lands before that entry is issued.
- Start/stop configuration: seq_len, gap_cycles and loop_en are latched on an accepted start and are ignored after that.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP, FINISH.
- IDLE, start with seq_len != 0: latch configuration, idx=0, busy=1, go to ISSUE next cycle.
- IDLE, start with seq_len == 0: done pulses one cycle later. No update is issued and busy stays 0.
- start while busy is ignored.
- ISSUE:
  - If spi_ready is low, hold in ISSUE.
  - If spi_ready is high, in one cycle: dds_control=tbl[idx], dds_control_update=1, word_idx=idx, clear timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - spi_ready low: go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches ACK_TIMEOUT: skip_count += 1 (saturates at 255), go to GAP.
  - Reason: the writer suppresses a word equal to its previous word, so spi_ready never falls.
- WAIT_DONE: spi_ready high goes to GAP.
- GAP:
  - Count gap_cycles cycles; gap 0 means zero extra cycles.
  - After the gap, if idx == seq_len-1: with loop go to idx=0 and ISSUE, otherwise go to FINISH.
  - Else idx += 1 and go to ISSUE.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- dds_control_update is high for exactly one cycle per issued word. dds_control holds its last value between updates.
- Abort:
  - Highest priority; any non-IDLE state goes to IDLE next cycle, busy=0, no done pulse.
  - No update is asserted in the cycle abort is sampled.
  - A writer transfer already in flight completes on its own. A following start waits in ISSUE for spi_ready.
- abort together with start in IDLE: start is ignored.
- skip_count clears only on reset.

Optional Feature:
Macro DDS_SEQ_DEDUP_EN.
- Defined: the sequencer keeps the last word it issued (reset 0).
  - In ISSUE, a table word equal to it is not issued: no update, skip_count += 1, word_idx updated, go straight to GAP.
  - WAIT_ACK still uses ACK_TIMEOUT as a safety net.
- Not defined: every word is issued and suppression is detected only by ACK_TIMEOUT.

Test Plan:
- Table [0x1234,0x5678,0x9ABC], seq_len=3, gap=10, loop=0, start; model writer -> 3 updates with those values, each issued only with spi_ready high; >=10 idle cycles between spi_ready rise and next update; one done pulse; busy falls with done; skip_count=0.
- Table [0xAAAA,0xAAAA], seq_len=2, model writer that suppresses repeats -> without macro: 2 updates, second times out after 8 cycles, skip_count=1. With DDS_SEQ_DEDUP_EN: 1 update, skip_count=1.
- seq_len=2, loop=1, gap=0, run 3 passes then abort during WAIT_DONE -> 6 updates with word_idx 0,1,0,1,0,1; busy low the cycle after abort; no done; next start holds in ISSUE until spi_ready rises.
- seq_len=0 start -> done one cycle later, no update, busy stays 0. start while busy -> ignored, update sequence unchanged.
- rstn low mid-sequence in WAIT_ACK -> next cycle all outputs 0, FSM IDLE; table retains prior contents and replays correctly after a new start.
- Overwrite tbl[2]=0xBEEF while word 1 is in WAIT_DONE -> third update carries 0xBEEF.
